// File: rtl/spi_mem_bridge.sv
// spi_mem_bridge: SPI mode-0 slave that decodes host frames into word memory requests and core run control.
// Define SPI_STATUS_EN to add the STATUS command (0x05) that reports {err_sticky, core_run}.
module spi_mem_bridge #(
   parameter int ADDR_W  = 16,
   parameter int RD_WAIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_sck,
   input  logic              spi_cs_n,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_we,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [31:0]       mem_req_wdata,
   input  logic              mem_rsp_valid,
   input  logic [31:0]       mem_rsp_rdata,
   output logic              core_run,
   output logic              err_sticky
);

   typedef enum logic [3:0] {
      S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RDWAIT, S_RDATA, S_CTRL, S_IGNORE, S_STATUS
   } state_t;

   localparam logic [7:0]  CMD_WRITE = 8'h02;
   localparam logic [7:0]  CMD_READ  = 8'h03;
   localparam logic [7:0]  CMD_RUN   = 8'h0F;
   localparam logic [7:0]  CMD_HALT  = 8'h10;
   localparam logic [31:0] MISS_WORD = 32'hDEAD_BEEF;

   state_t            state;
   logic [2:0]        sck_sync;
   logic [1:0]        cs_sync, mosi_sync;
   logic [30:0]       rx_sh;
   logic [31:0]       tx_sh, rdata_buf;
   logic [7:0]        bit_cnt;
   logic [4:0]        out_cnt;
   logic              is_read, rsp_full, out_busy;
   logic [ADDR_W-1:0] cur_addr;
   // Every read launch gets an id; a response is used only if it belongs to the word awaiting data.
   logic [3:0]        launch_ctr, word_id, req_id, out_id;

   logic              sck_rise, sck_fall, cs_high, mosi_bit;
   logic              launch_rd, launch_wr, req_busy, rsp_hit, data_ok;
   logic [31:0]       rx_word, rd_word;
   logic [ADDR_W-1:0] addr_in, launch_addr;

   always_comb begin
      sck_rise    = sck_sync[1] & ~sck_sync[2];
      sck_fall    = ~sck_sync[1] & sck_sync[2];
      cs_high     = cs_sync[1];
      mosi_bit    = mosi_sync[1];
      rx_word     = {rx_sh, mosi_bit};
      addr_in     = ADDR_W'(rx_word[15:0]) & ~(ADDR_W'(3));
      req_busy    = mem_req_valid & ~mem_req_ready;
      rsp_hit     = mem_rsp_valid & out_busy & (out_id == word_id);
      data_ok     = rsp_full | rsp_hit;
      rd_word     = rsp_full ? rdata_buf : (rsp_hit ? mem_rsp_rdata : MISS_WORD);
      launch_rd   = ~cs_high & is_read &
                    ((state == S_ADDR && sck_rise && bit_cnt == 8'd15) ||
                     (state == S_RDATA && sck_fall && out_cnt == 5'd31));
      launch_wr   = ~cs_high & (state == S_WDATA) & sck_rise & (bit_cnt == 8'd31);
      launch_addr = (state == S_ADDR) ? addr_in : cur_addr;
   end

`ifdef SPI_STATUS_EN
   logic [7:0] status_byte;
   assign status_byte = {6'b0, err_sticky, core_run};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         sck_sync      <= '0;
         cs_sync       <= 2'b11;
         mosi_sync     <= '0;
         rx_sh         <= '0;
         tx_sh         <= '0;
         rdata_buf     <= '0;
         bit_cnt       <= '0;
         out_cnt       <= '0;
         is_read       <= 1'b0;
         rsp_full      <= 1'b0;
         out_busy      <= 1'b0;
         cur_addr      <= '0;
         launch_ctr    <= '0;
         word_id       <= '0;
         req_id        <= '0;
         out_id        <= '0;
         spi_miso      <= 1'b0;
         spi_miso_oe   <= 1'b0;
         mem_req_valid <= 1'b0;
         mem_req_we    <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
         core_run      <= 1'b0;
         err_sticky    <= 1'b0;
      end else begin
         sck_sync    <= {sck_sync[1:0], spi_sck};
         cs_sync     <= {cs_sync[0], spi_cs_n};
         mosi_sync   <= {mosi_sync[0], spi_mosi};
         spi_miso_oe <= ~cs_high;
         if (sck_rise) rx_sh <= rx_word[30:0];

         // NOTE: non-blocking updates later in this block override earlier ones; a launch
         // re-raising valid in the cycle the previous request is accepted relies on that.
         if (mem_rsp_valid) out_busy <= 1'b0;
         if (mem_req_valid && mem_req_ready) begin
            mem_req_valid <= 1'b0;
            if (!mem_req_we) begin
               out_busy <= 1'b1;
               out_id   <= req_id;
            end
         end
         if (rsp_hit) begin
            rdata_buf <= mem_rsp_rdata;
            rsp_full  <= 1'b1;
         end

         if (launch_rd || launch_wr) begin
            launch_ctr <= launch_ctr + 4'd1;
            cur_addr   <= launch_addr + ADDR_W'(4);
            if (!req_busy) begin
               mem_req_valid <= 1'b1;
               mem_req_we    <= launch_wr;
               mem_req_addr  <= launch_addr;
               req_id        <= launch_ctr;
               if (launch_wr) mem_req_wdata <= rx_word;
            end else if (launch_wr) begin
               err_sticky <= 1'b1;
            end
         end

         if (cs_high) begin
            state    <= S_IDLE;
            spi_miso <= 1'b0;
            rsp_full <= 1'b0;
            word_id  <= launch_ctr;
         end else begin
            case (state)
               S_IDLE: begin
                  state   <= S_CMD;
                  bit_cnt <= '0;
               end
               S_CMD: if (sck_rise) begin
                  bit_cnt <= bit_cnt + 8'd1;
                  if (bit_cnt == 8'd7) begin
                     bit_cnt <= '0;
                     out_cnt <= '0;
                     is_read <= 1'b0;
                     case (rx_word[7:0])
                        CMD_WRITE: state <= S_ADDR;
                        CMD_READ: begin
                           state   <= S_ADDR;
                           is_read <= 1'b1;
                        end
                        CMD_RUN, CMD_HALT: begin
                           state      <= S_CTRL;
                           core_run   <= (rx_word[7:0] == CMD_RUN);
                           err_sticky <= 1'b0;
                        end
`ifdef SPI_STATUS_EN
                        8'h05:   state <= S_STATUS;
`endif
                        default: state <= S_IGNORE;
                     endcase
                  end
               end
               S_ADDR: if (sck_rise) begin
                  bit_cnt <= bit_cnt + 8'd1;
                  if (bit_cnt == 8'd15) begin
                     bit_cnt <= '0;
                     state   <= is_read ? S_RDWAIT : S_WDATA;
                     if (!is_read) cur_addr <= addr_in;
                  end
               end
               S_WDATA: if (sck_rise) begin
                  bit_cnt <= (bit_cnt == 8'd31) ? 8'd0 : bit_cnt + 8'd1;
               end
               S_RDWAIT: if (sck_rise) begin
                  bit_cnt <= bit_cnt + 8'd1;
                  if (bit_cnt == 8'(RD_WAIT - 1)) state <= S_RDATA;
               end
               S_RDATA: if (sck_fall) begin
                  out_cnt <= out_cnt + 5'd1;
                  if (out_cnt == 5'd0) begin
                     // Data deadline for this word: use the response if it arrived, else the miss marker.
                     spi_miso <= rd_word[31];
                     tx_sh    <= {rd_word[30:0], 1'b0};
                     rsp_full <= 1'b0;
                     word_id  <= word_id + 4'd1;
                     if (!data_ok) err_sticky <= 1'b1;
                  end else begin
                     spi_miso <= tx_sh[31];
                     tx_sh    <= {tx_sh[30:0], 1'b0};
                  end
               end
`ifdef SPI_STATUS_EN
               S_STATUS: if (sck_fall) begin
                  spi_miso <= status_byte[3'd7 - out_cnt[2:0]];
                  out_cnt  <= out_cnt + 5'd1;
               end
`endif
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_mem_bridge.sv
// tb_spi_mem_bridge: drives SPI frames from a host model and checks requests and MISO data
// against a behavioural memory model; directed frames first, then randomized burst write/read-back.
module tb_spi_mem_bridge;

   localparam int HALF    = 8;
   localparam int RD_WAIT = 8;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [31:0] wdata;
   } req_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        spi_sck = 1'b0;
   logic        spi_cs_n = 1'b1;
   logic        spi_mosi = 1'b0;
   logic        spi_miso, spi_miso_oe;
   logic        mem_req_valid, mem_req_we;
   logic        mem_req_ready = 1'b0;
   logic [15:0] mem_req_addr;
   logic [31:0] mem_req_wdata;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_rdata = '0;
   logic        core_run, err_sticky;

   int n_checks = 0;
   int n_errors = 0;

   // Memory responder state
   int          ready_mode = 0;
   int          cyc = 0;
   logic        pend_valid = 1'b0;
   int          pend_due = 0;
   logic [31:0] pend_data = '0;
   req_t        cur_req;
   req_t        log_q[$];
   logic [31:0] mem [logic [15:0]];
   logic [31:0] ref_mem [logic [15:0]];
   logic [31:0] rd_q[$];
   logic [31:0] wr_words [4];

   spi_mem_bridge #(.ADDR_W(16), .RD_WAIT(RD_WAIT)) dut (
      .clk           (clk),
      .rst           (rst),
      .spi_sck       (spi_sck),
      .spi_cs_n      (spi_cs_n),
      .spi_mosi      (spi_mosi),
      .spi_miso      (spi_miso),
      .spi_miso_oe   (spi_miso_oe),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_we    (mem_req_we),
      .mem_req_addr  (mem_req_addr),
      .mem_req_wdata (mem_req_wdata),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_rdata (mem_rsp_rdata),
      .core_run      (core_run),
      .err_sticky    (err_sticky)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #800000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
      $fatal(1, "simulation time limit");
   end

   // Word memory: logs accepted requests, stores writes, answers reads 3 clk after acceptance.
   always @(negedge clk) begin
      cyc++;
      mem_rsp_valid = 1'b0;
      case (ready_mode)
         0:       mem_req_ready = 1'b0;
         1:       mem_req_ready = 1'b1;
         default: mem_req_ready = 1'($urandom_range(0, 1));
      endcase
      if (pend_valid && cyc == pend_due) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_rdata = pend_data;
         pend_valid    = 1'b0;
      end
      if (!rst && mem_req_valid && mem_req_ready) begin
         cur_req.we    = mem_req_we;
         cur_req.addr  = mem_req_addr;
         cur_req.wdata = mem_req_wdata;
         log_q.push_back(cur_req);
         if (mem_req_we) begin
            mem[mem_req_addr] = mem_req_wdata;
         end else begin
            pend_data  = mem.exists(mem_req_addr) ? mem[mem_req_addr] : {16'hA5A5, mem_req_addr};
            pend_due   = cyc + 3;
            pend_valid = 1'b1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cs_begin();
      spi_cs_n = 1'b0;
      wait_clk(6);
   endtask

   task automatic cs_end();
      wait_clk(20);
      spi_cs_n = 1'b1;
      wait_clk(10);
   endtask

   // Mode 0 host: MOSI set while SCK low, MISO sampled just before the rising edge.
   task automatic shift(input int n, input logic [31:0] tx, output logic [31:0] rx);
      rx = '0;
      for (int i = n - 1; i >= 0; i--) begin
         spi_mosi = tx[i];
         wait_clk(HALF);
         rx = {rx[30:0], spi_miso};
         spi_sck = 1'b1;
         wait_clk(HALF);
         spi_sck = 1'b0;
      end
   endtask

   task automatic cmd_frame(input logic [7:0] cmd);
      logic [31:0] rx;
      cs_begin();
      shift(8, {24'h0, cmd}, rx);
      cs_end();
   endtask

   task automatic write_frame(input logic [15:0] addr, input int n_words);
      logic [31:0] rx;
      cs_begin();
      shift(8, 32'h02, rx);
      shift(16, {16'h0, addr}, rx);
      for (int w = 0; w < n_words; w++) shift(32, wr_words[w], rx);
      cs_end();
   endtask

   task automatic read_frame(input logic [15:0] addr, input int n_words);
      logic [31:0] rx;
      cs_begin();
      shift(8, 32'h03, rx);
      shift(16, {16'h0, addr}, rx);
      shift(RD_WAIT, 32'h0, rx);
      for (int w = 0; w < n_words; w++) begin
         shift(32, 32'h0, rx);
         rd_q.push_back(rx);
      end
      cs_end();
   endtask

   function automatic logic [15:0] word_addr(input logic [15:0] base, input int w);
      return 16'((int'(base) & 32'hFFFC) + 4 * w);
   endfunction

   initial begin
      logic [31:0] rx;
      logic [15:0] base;
      logic [7:0]  exp_status;
      int          n;

      wait_clk(5);
      rst = 1'b0;
      wait_clk(5);
      check("rst_miso", spi_miso, 0);
      check("rst_miso_oe", spi_miso_oe, 0);
      check("rst_valid", mem_req_valid, 0);
      check("rst_we", mem_req_we, 0);
      check("rst_addr", mem_req_addr, 0);
      check("rst_wdata", mem_req_wdata, 0);
      check("rst_core_run", core_run, 0);
      check("rst_err", err_sticky, 0);

      // Two-word write burst
      ready_mode = 1;
      log_q.delete();
      cs_begin();
      check("miso_oe_cs_low", spi_miso_oe, 1);
      shift(8, 32'h02, rx);
      shift(16, 32'h0010, rx);
      shift(32, 32'h1122_3344, rx);
      shift(32, 32'h5566_7788, rx);
      cs_end();
      check("wr_nreq", log_q.size(), 2);
      if (log_q.size() >= 2) begin
         check("wr0_we", log_q[0].we, 1);
         check("wr0_addr", log_q[0].addr, 16'h0010);
         check("wr0_data", log_q[0].wdata, 32'h1122_3344);
         check("wr1_we", log_q[1].we, 1);
         check("wr1_addr", log_q[1].addr, 16'h0014);
         check("wr1_data", log_q[1].wdata, 32'h5566_7788);
      end
      check("miso_oe_cs_high", spi_miso_oe, 0);

      // Two-word read across the address wrap
      mem[16'hFFFC] = 32'hCAFE_F00D;
      mem[16'h0000] = 32'h0123_4567;
      log_q.delete();
      rd_q.delete();
      read_frame(16'hFFFC, 2);
      check("rd_nwords", rd_q.size(), 2);
      if (rd_q.size() >= 2) begin
         check("rd0_miso", rd_q[0], 32'hCAFE_F00D);
         check("rd1_miso", rd_q[1], 32'h0123_4567);
      end
      check("rd_nreq_ge2", log_q.size() >= 2, 1);
      if (log_q.size() >= 2) begin
         check("rd0_addr", log_q[0].addr, 16'hFFFC);
         check("rd0_we", log_q[0].we, 0);
         check("rd1_addr_wrap", log_q[1].addr, 16'h0000);
      end
      check("rd_err_clear", err_sticky, 0);

      // Read while memory never accepts: miss marker and sticky error
      ready_mode = 0;
      rd_q.delete();
      read_frame(16'h0100, 1);
      check("miss_miso", rd_q.size() > 0 ? rd_q[0] : 32'h0, 32'hDEAD_BEEF);
      check("miss_err", err_sticky, 1);
      check("miss_valid_held", mem_req_valid, 1);
      check("miss_addr_held", mem_req_addr, 16'h0100);
      ready_mode = 1;
      wait_clk(20);
      log_q.delete();

      cmd_frame(8'h0F);
      check("run_core_run", core_run, 1);
      check("run_err_clear", err_sticky, 0);

      // STATUS byte (or IGNORE when the command is not built in)
`ifdef SPI_STATUS_EN
      exp_status = 8'h01;
`else
      exp_status = 8'h00;
`endif
      cs_begin();
      shift(8, 32'h05, rx);
      shift(16, 32'h0, rx);
      cs_end();
      check("status_miso", rx[15:0], {exp_status, exp_status});
      check("status_core_run", core_run, 1);
      check("status_err", err_sticky, 0);
      check("status_no_req", log_q.size(), 0);

      // Abort a write 20 bits into its data word
      cs_begin();
      shift(8, 32'h02, rx);
      shift(16, 32'h0040, rx);
      shift(20, $urandom, rx);
      cs_end();
      check("abort_no_req", log_q.size(), 0);
      rd_q.delete();
      read_frame(16'h0013, 1);
      check("after_abort_miso", rd_q.size() > 0 ? rd_q[0] : 32'h0, 32'h1122_3344);
      check("after_abort_addr", log_q.size() > 0 ? {16'h0, log_q[0].addr} : 32'hFFFF_FFFF, 32'h0010);

      cmd_frame(8'h10);
      check("halt_core_run", core_run, 0);

      // Randomized write bursts read back against the reference memory
      for (int it = 0; it < 5; it++) begin
         n    = $urandom_range(1, 3);
         base = 16'($urandom);
         for (int w = 0; w < n; w++) begin
            wr_words[w] = $urandom;
            ref_mem[word_addr(base, w)] = wr_words[w];
         end
         ready_mode = 2;
         log_q.delete();
         write_frame(base, n);
         check("rnd_wr_nreq", log_q.size(), n);
         for (int w = 0; w < n; w++) begin
            if (w < log_q.size()) begin
               check("rnd_wr_addr", log_q[w].addr, word_addr(base, w));
               check("rnd_wr_data", log_q[w].wdata, wr_words[w]);
            end
         end
         ready_mode = 1;
         wait_clk(10);
         log_q.delete();
         rd_q.delete();
         read_frame(base, n);
         check("rnd_rd_nwords", rd_q.size(), n);
         for (int w = 0; w < n; w++) begin
            if (w < rd_q.size()) check("rnd_rd_miso", rd_q[w], ref_mem[word_addr(base, w)]);
            if (w < log_q.size()) check("rnd_rd_addr", log_q[w].addr, word_addr(base, w));
         end
         check("rnd_err", err_sticky, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
